cmp32_arbiter: RTL and testbench

//  Shares one cmp32 32-bit equality comparator between NUM_REQ requesters, e.g. branch unit and LSQ address check.
//  - Round-robin arbitration, valid/ready handshakes on both sides.
//  - One registered result stage.

---
 rtl/cmp_arb_pkg.sv | 38 +++
 rtl/cmp32.sv | 16 +
 rtl/rr_arbiter.sv | 55 +++++
 rtl/cmp32_arbiter.sv | 110 +++++++++++
 tb/tb_cmp32_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_arb_pkg
//  Description : Shared types, widths and the round-robin grant function.
//  Revision    : 1.0
// ============================================================================
package cmp_arb_pkg;

    localparam int CMP_W   = 32;
    localparam int MAX_REQ = 8;

    typedef logic [CMP_W-1:0] cmp_operand_t;

    // One-hot grant to the first valid requester after ptr, wrapping at num.
    function automatic logic [MAX_REQ-1:0] rr_next(
        input logic [2:0]         ptr,
        input logic [MAX_REQ-1:0] valid,
        input int                 num
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= num) begin
                idx = (int'(ptr) + k) % num;
                if (!found && valid[idx[2:0]]) begin
                    grant[idx[2:0]] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp32.sv
`default_nettype none
// ============================================================================
//  Module      : cmp32
//  Description : 32-bit equality comparator.
//  Revision    : 1.0
// ============================================================================
module cmp32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_eq
);

    assign o_eq = (i_a == i_b);

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin one-hot arbiter; pointer moves to the winner on accept.
//  Revision    : 1.0
// ============================================================================
module rr_arbiter
    import cmp_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_id
);

    logic [PTR_W-1:0]   r_ptr;
    logic [MAX_REQ-1:0] w_valid_ext;
    logic [MAX_REQ-1:0] w_grant_ext;

    assign w_valid_ext = MAX_REQ'(i_valid);
    assign w_grant_ext = rr_next(3'(r_ptr), w_valid_ext, NUM_REQ);
    assign o_grant     = w_grant_ext[NUM_REQ-1:0];

    generate
        if (NUM_REQ < MAX_REQ) begin : g_unused_grant
            logic w_unused;
            assign w_unused = |w_grant_ext[MAX_REQ-1:NUM_REQ];
        end
    endgenerate

    always_comb begin
        o_grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_grant[i]) begin
                o_grant_id = PTR_W'(i);
            end
        end
    end

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PTR_W'(NUM_REQ - 1);
        end else if (i_accept) begin
            r_ptr <= o_grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmp32_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cmp32_arbiter
//  Description : Shares one cmp32 between NUM_REQ requesters with a registered
//                result stage. Define CMP32_ARBITER_LT_EN to add rsp_lt/rsp_ltu.
//  Revision    : 1.0
// ============================================================================
module cmp32_arbiter
    import cmp_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TAG_W   = 6,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*CMP_W-1:0] req_a,
    input  logic [NUM_REQ*CMP_W-1:0] req_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_eq
`ifdef CMP32_ARBITER_LT_EN
    ,
    output logic                     rsp_lt,
    output logic                     rsp_ltu
`endif
);

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_stage_free;
    logic               w_accept;
    cmp_operand_t       w_a;
    cmp_operand_t       w_b;
    logic [TAG_W-1:0]   w_tag;
    logic               w_eq;

    assign w_stage_free = !rsp_valid || rsp_ready;
    assign req_ready    = w_grant & {NUM_REQ{w_stage_free}};
    // A grant is only ever issued to a valid requester.
    assign w_accept     = |req_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (req_valid),
        .i_accept   (w_accept),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_a   = req_a[CMP_W*i +: CMP_W];
                w_b   = req_b[CMP_W*i +: CMP_W];
                w_tag = req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    cmp32 u_cmp32 (
        .i_a  (w_a),
        .i_b  (w_b),
        .o_eq (w_eq)
    );

`ifdef CMP32_ARBITER_LT_EN
    logic w_lt;
    logic w_ltu;
    assign w_lt  = $signed(w_a) < $signed(w_b);
    assign w_ltu = w_a < w_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
            rsp_eq    <= 1'b0;
`ifdef CMP32_ARBITER_LT_EN
            rsp_lt    <= 1'b0;
            rsp_ltu   <= 1'b0;
`endif
        end else if (w_accept) begin
            rsp_valid <= 1'b1;
            rsp_id    <= w_grant_id;
            rsp_tag   <= w_tag;
            rsp_eq    <= w_eq;
`ifdef CMP32_ARBITER_LT_EN
            rsp_lt    <= w_lt;
            rsp_ltu   <= w_ltu;
`endif
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp32_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp32_arbiter
//  Description : Self-checking bench for cmp32_arbiter (optionally with
//                CMP32_ARBITER_LT_EN defined).
//  Revision    : 1.0
// ============================================================================
module tb_cmp32_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*TW-1:0] req_tag;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [TW-1:0]   rsp_tag;
    logic            rsp_eq;
`ifdef CMP32_ARBITER_LT_EN
    logic            rsp_lt;
    logic            rsp_ltu;
`endif

    cmp32_arbiter #(
        .NUM_REQ (N),
        .TAG_W   (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .rsp_eq    (rsp_eq)
`ifdef CMP32_ARBITER_LT_EN
        ,
        .rsp_lt    (rsp_lt),
        .rsp_ltu   (rsp_ltu)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: owner of the result slot and the last winner.
    int            m_ptr = N - 1;
    bit            m_valid = 1'b0;
    int            m_id = 0;
    logic [TW-1:0] m_tag = '0;
    bit            m_eq = 1'b0;
    bit            m_lt = 1'b0;
    bit            m_ltu = 1'b0;

    always @(negedge clk) begin
        int           g;
        int           j;
        logic [N-1:0] exp_ready;
        logic [31:0]  a;
        logic [31:0]  b;
        if (!rst_n) begin
            m_ptr = N - 1; m_valid = 1'b0; m_id = 0; m_tag = '0;
            m_eq = 1'b0; m_lt = 1'b0; m_ltu = 1'b0;
        end
        g = -1;
        if (!m_valid || rsp_ready) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("model req_ready", 64'(req_ready), 64'(exp_ready));
        check("model rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("model rsp_id",    64'(rsp_id),    64'(m_id));
        check("model rsp_tag",   64'(rsp_tag),   64'(m_tag));
        check("model rsp_eq",    64'(rsp_eq),    64'(m_eq));
`ifdef CMP32_ARBITER_LT_EN
        check("model rsp_lt",    64'(rsp_lt),    64'(m_lt));
        check("model rsp_ltu",   64'(rsp_ltu),   64'(m_ltu));
`endif
        if (rst_n) begin
            if (g >= 0) begin
                a       = req_a[32*g +: 32];
                b       = req_b[32*g +: 32];
                m_valid = 1'b1;
                m_id    = g;
                m_tag   = req_tag[TW*g +: TW];
                m_eq    = (a == b);
                m_lt    = ($signed(a) < $signed(b));
                m_ltu   = (a < b);
                m_ptr   = g;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
        req_a[32*i +: 32]   = a;
        req_b[32*i +: 32]   = b;
        req_tag[TW*i +: TW] = t;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n     = 1'b1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          acc;
        int          cyc;
        logic [N-1:0] taken;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        apply_reset();
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_tag",   64'(rsp_tag),   64'd0);

        // Single request from requester 0
        rsp_ready = 1'b1;
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5);
        req_valid = 4'b0001;
        settle();
        check("t1 req_ready", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        check("t1 rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1 rsp_id",    64'(rsp_id),    64'd0);
        check("t1 rsp_tag",   64'(rsp_tag),   64'd5);
        check("t1 rsp_eq",    64'(rsp_eq),    64'd1);

        // All requesters held valid: strict rotation
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++)
            set_req(i, 32'(i), (i % 2 == 1) ? 32'(i + 1) : 32'(i), TW'(10 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("t2 grant", 64'(req_ready), 64'd1 << (k % 4));
            step();
            check("t2 rsp_id",    64'(rsp_id),    64'(k % 4));
            check("t2 rsp_valid", 64'(rsp_valid), 64'd1);
            check("t2 rsp_eq",    64'(rsp_eq),    64'((k % 2) == 0));
        end
        req_valid = '0;

        // Backpressure holds the result and blocks grants
        set_req(2, 32'h0, 32'hFFFF_FFFF, 6'd22);
        set_req(3, 32'd7, 32'd7, 6'd33);
        set_req(0, 32'd9, 32'd9, 6'd40);
        req_valid = 4'b0100;
        settle();
        check("t3 grant2", 64'(req_ready), 64'b0100);
        step();
        req_valid = 4'b1001;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("t3 stall ready", 64'(req_ready), 64'd0);
            check("t3 stall id",    64'(rsp_id),    64'd2);
            check("t3 stall eq",    64'(rsp_eq),    64'd0);
            check("t3 stall valid", 64'(rsp_valid), 64'd1);
            step();
        end
        rsp_ready = 1'b1;
        settle();
        check("t3 resume grant3", 64'(req_ready), 64'b1000);
        step();
        req_valid = 4'b0001;
        settle();
        check("t3 then grant0", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;

        // Back-to-back accepts, no bubble
        set_req(1, 32'h0, 32'h0, 6'd1);
        req_valid = 4'b0010;
        settle();
        check("t4 first ready", 64'(req_ready), 64'b0010);
        step();
        set_req(1, 32'hFFFF_FFFF, 32'h0, 6'd2);
        settle();
        check("t4 second ready", 64'(req_ready), 64'b0010);
        check("t4 first eq",     64'(rsp_eq),    64'd1);
        step();
        req_valid = '0;
        check("t4 second valid", 64'(rsp_valid), 64'd1);
        check("t4 second eq",    64'(rsp_eq),    64'd0);
        check("t4 second tag",   64'(rsp_tag),   64'd2);

        // Asynchronous reset while a result is pending
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        settle();
        check("t5 async rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5 async rsp_tag",   64'(rsp_tag),   64'd0);
        step();
        step();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        settle();
        check("t5 first grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        check("t5 rsp_id", 64'(rsp_id), 64'd0);
        rsp_ready = 1'b1;

`ifdef CMP32_ARBITER_LT_EN
        set_req(0, 32'hFFFF_FFFF, 32'h1, 6'd3);
        req_valid = 4'b0001;
        settle();
        step();
        req_valid = '0;
        check("t6 rsp_lt",  64'(rsp_lt),  64'd1);
        check("t6 rsp_ltu", 64'(rsp_ltu), 64'd0);
        check("t6 rsp_eq",  64'(rsp_eq),  64'd0);
`endif

        // Random traffic with random backpressure, checked by the model
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    ra = $urandom;
                    rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                    if ($urandom_range(0, 7) == 0) rb = ra ^ 32'h8000_0000;
                    set_req(i, ra, rb, TW'($urandom));
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            settle();
            taken = req_ready & req_valid;
            acc += $countones(taken);
            step();
            req_valid = req_valid & ~taken;
            cyc++;
        end
        check("random accept budget", 64'(acc >= 1000), 64'd1);

        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
